csa_tree_pipe: RTL and testbench

//   Parametrised, pipelined multi-operand adder: N_OPS operands of WIDTH bits are reduced by a

---
 rtl/csa_tree_pipe_pkg.sv | 37 +++
 rtl/csa_tree_pipe_csa_3_2.sv | 17 +
 rtl/csa_tree_pipe.sv | 104 ++++++++++
 tb/tb_csa_tree_pipe.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_tree_pipe_pkg.sv
// Elaboration-time sizing helpers for the pipelined carry-save adder tree.
// Every function here is a constant function used only for generate sizing.
package csa_tree_pipe_pkg;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  // Row count entering level lvl: each level folds every full group of three into two.
  function automatic int rows_at_level(input int n, input int lvl);
    int rows;
    rows = n;
    for (int i = 0; i < lvl; i++) rows = rows - rows / 3;
    return rows;
  endfunction

  function automatic int csa_levels(input int n);
    int rows;
    int lv;
    rows = n;
    lv = 0;
    while (rows > 2) begin
      rows = rows - rows / 3;
      lv++;
    end
    return lv;
  endfunction

endpackage

// File: rtl/csa_tree_pipe_csa_3_2.sv
// Bitwise 3:2 compressor: sum row plus unshifted carry row.
// Latency: combinational.
// Backpressure: none, pure logic.
module csa_3_2 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] s,
  output logic [W-1:0] co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_tree_pipe.sv
// Pipelined multi-operand adder: Wallace tree of 3:2 CSAs plus a registered final add.
// Latency: csa_levels(N_OPS)+1 cycles from accepted input to out_valid.
// Backpressure: a held output freezes every rank; in_ready drops for the same cycle.
module csa_tree_pipe
  import csa_tree_pipe_pkg::*;
#(
  parameter int N_OPS  = 10,
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0,
  localparam int OUT_W = WIDTH + clog2(N_OPS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_OPS*WIDTH-1:0] ops_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       sum
);

  localparam int LEVELS = csa_levels(N_OPS);

  logic             stall;
  logic [OUT_W-1:0] ext_rows [N_OPS];
  logic [OUT_W-1:0] cpa_a;
  logic [OUT_W-1:0] cpa_b;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  for (genvar k = 0; k < N_OPS; k++) begin : g_ext
    logic [WIDTH-1:0] op;
    assign op = ops_in[k*WIDTH +: WIDTH];
    if (SIGNED != 0) begin : g_sx
      assign ext_rows[k] = OUT_W'($signed(op));
    end else begin : g_zx
      assign ext_rows[k] = OUT_W'(op);
    end
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int N_IN  = rows_at_level(N_OPS, l);
    localparam int N_GRP = N_IN / 3;
    localparam int N_OUT = N_IN - N_GRP;

    logic [OUT_W-1:0] src [N_IN];
    logic [OUT_W-1:0] nxt [N_OUT];
    logic [OUT_W-1:0] q   [N_OUT];
    logic             vld_in;
    logic             vld_q;

    if (l == 0) begin : g_first
      assign src    = ext_rows;
      assign vld_in = in_valid;
    end else begin : g_next
      assign src    = g_lvl[l-1].q;
      assign vld_in = g_lvl[l-1].vld_q;
    end

    for (genvar g = 0; g < N_GRP; g++) begin : g_csa
      logic [OUT_W-1:0] s_row;
      logic [OUT_W-1:0] c_row;
      csa_3_2 #(.W(OUT_W)) u_csa (
        .a  (src[3*g]),
        .b  (src[3*g+1]),
        .c  (src[3*g+2]),
        .s  (s_row),
        .co (c_row)
      );
      assign nxt[2*g]   = s_row;
      // Carry weight is one bit higher; the bit shifted past OUT_W-1 is dropped (mod 2^OUT_W).
      assign nxt[2*g+1] = c_row << 1;
    end

    for (genvar p = 0; p < N_IN - 3*N_GRP; p++) begin : g_pass
      assign nxt[2*N_GRP+p] = src[3*N_GRP+p];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        vld_q <= 1'b0;
        for (int r = 0; r < N_OUT; r++) q[r] <= '0;
      end else if (!stall) begin
        vld_q <= vld_in;
        for (int r = 0; r < N_OUT; r++) q[r] <= nxt[r];
      end
    end
  end

  assign cpa_a = g_lvl[LEVELS-1].q[0];
  assign cpa_b = g_lvl[LEVELS-1].q[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      sum       <= '0;
    end else if (!stall) begin
      out_valid <= g_lvl[LEVELS-1].vld_q;
      sum       <= cpa_a + cpa_b;
    end
  end

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Directed bench for csa_tree_pipe: unsigned and signed 10x8 instances share stimulus,
// plus a 3x4 instance for the single-level configuration.
module tb_csa_tree_pipe;

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  logic        in_valid   = 1'b0;
  logic        out_ready  = 1'b1;
  logic [79:0] ops        = '0;
  logic        in_ready;
  logic        out_valid;
  logic [11:0] sum_u;
  logic        in_ready_s;
  logic        out_valid_s;
  logic [11:0] sum_s;

  logic [11:0] ops3       = '0;
  logic        in_valid3  = 1'b0;
  logic        out_ready3 = 1'b1;
  logic        in_ready3;
  logic        out_valid3;
  logic [5:0]  sum3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  csa_tree_pipe #(.N_OPS(10), .WIDTH(8), .SIGNED(0)) u_dut_u (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .ops_in(ops),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum_u)
  );

  csa_tree_pipe #(.N_OPS(10), .WIDTH(8), .SIGNED(1)) u_dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s), .ops_in(ops),
    .out_valid(out_valid_s), .out_ready(out_ready), .sum(sum_s)
  );

  csa_tree_pipe #(.N_OPS(3), .WIDTH(4), .SIGNED(0)) u_dut_3 (
    .clk(clk), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3), .ops_in(ops3),
    .out_valid(out_valid3), .out_ready(out_ready3), .sum(sum3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] gen(input int seed, input int i);
    logic [79:0] o;
    for (int k = 0; k < 10; k++) o[k*8 +: 8] = 8'(seed*7 + i*37 + k*29);
    return o;
  endfunction

  function automatic logic [11:0] ref10(input logic [79:0] o, input bit sgn);
    int acc;
    logic [7:0] b;
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      b = o[k*8 +: 8];
      if (sgn) acc += int'($signed(b));
      else     acc += int'(b);
    end
    return acc[11:0];
  endfunction

  // One isolated set through an empty pipe with out_ready held high.
  task automatic run_one(input string tag, input logic [79:0] o,
                         input logic [11:0] eu, input logic [11:0] es);
    int lat;
    ops = o;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, lat, 6);
    check({tag, "_u"}, sum_u, eu);
    check({tag, "_s"}, sum_s, es);
    check({tag, "_svld"}, out_valid_s, out_valid);
    tick();
    check({tag, "_drop"}, out_valid, 0);
  endtask

  // Back-to-back sets; out_ready is low for stall_len cycles starting at stall_at.
  task automatic stream(input string tag, input int n_sets, input int stall_at,
                        input int stall_len, input int seed);
    logic [11:0] eu_q[$];
    logic [11:0] es_q[$];
    logic [11:0] held;
    logic [11:0] eu;
    logic [11:0] es;
    bit prev_stall;
    bit acc;
    int sent;
    int got;
    int first;
    int last;
    prev_stall = 0;
    sent = 0;
    got = 0;
    first = -1;
    last = -1;
    held = '0;
    ops = gen(seed, 0);
    in_valid = 1'b1;
    for (int c = 0; c < n_sets + 40 && got < n_sets; c++) begin
      out_ready = !(c >= stall_at && c < stall_at + stall_len);
      #1;
      if (prev_stall) check({tag, "_hold"}, sum_u, held);
      prev_stall = out_valid && !out_ready;
      if (prev_stall) begin
        held = sum_u;
        check({tag, "_rdy_low"}, in_ready, 0);
        check({tag, "_rdy_low_s"}, in_ready_s, 0);
      end
      if (out_valid && out_ready) begin
        if (eu_q.size() == 0) begin
          check({tag, "_extra"}, out_valid, 0);
        end else begin
          eu = eu_q.pop_front();
          es = es_q.pop_front();
          check({tag, "_u"}, sum_u, eu);
          check({tag, "_s"}, sum_s, es);
          got++;
          if (first < 0) first = c;
          last = c;
        end
      end
      acc = in_valid && in_ready;
      if (acc) begin
        eu_q.push_back(ref10(ops, 1'b0));
        es_q.push_back(ref10(ops, 1'b1));
      end
      tick();
      if (acc) begin
        sent++;
        if (sent < n_sets) ops = gen(seed, sent);
        else in_valid = 1'b0;
      end
    end
    out_ready = 1'b1;
    check({tag, "_count"}, got, n_sets);
    check({tag, "_span"}, last - first + 1, n_sets + stall_len);
  endtask

  initial begin
    int lat;
    int nv;
    int got3;
    logic [11:0] r;
    logic [5:0] exp3;
    logic [5:0] q3[$];

    // Reset held for two cycles.
    tick();
    check("rst_vld0", out_valid, 0);
    check("rst_sum0", sum_u, 0);
    tick();
    check("rst_vld1", out_valid, 0);
    check("rst_vld3", out_valid3, 0);
    reset = 1'b0;
    #1;
    check("rst_rdy", in_ready, 1);

    run_one("zero", 80'h0, 12'h000, 12'h000);
    run_one("seq", {8'd10, 8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 12'h037, 12'h037);
    run_one("mix", {8'd10, 8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd13, 8'd2, 8'd11}, 12'h04B, 12'h04B);
    run_one("ff", {10{8'hFF}}, 12'h9F6, 12'hFF6);
    run_one("m128", {10{8'h80}}, 12'h500, 12'hB00);

    stream("b2b", 8, 1000, 0, 1);
    stream("bp", 12, 8, 3, 5);

    // Reset lands on the cycle the third set is presented; all three must vanish.
    ops = gen(3, 0);
    in_valid = 1'b1;
    tick();
    ops = gen(3, 1);
    tick();
    ops = gen(3, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    check("mid_rst_vld", out_valid, 0);
    check("mid_rst_sum", sum_u, 0);
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) nv++;
    end
    check("mid_rst_flush", nv, 0);
    run_one("post_rst", {8'd10, 8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd13, 8'd2, 8'd11}, 12'h04B, 12'h04B);

    // Three-operand, single-level instance.
    check("n3_rdy", in_ready3, 1);
    ops3 = {4'd15, 4'd15, 4'd15};
    in_valid3 = 1'b1;
    tick();
    in_valid3 = 1'b0;
    lat = 1;
    while (!out_valid3 && lat < 20) begin
      tick();
      lat++;
    end
    check("n3_lat", lat, 2);
    check("n3_sum", sum3, 6'h2D);
    tick();
    check("n3_drop", out_valid3, 0);

    got3 = 0;
    for (int c = 0; c < 110; c++) begin
      if (out_valid3) begin
        if (q3.size() == 0) begin
          check("n3_extra", out_valid3, 0);
        end else begin
          exp3 = q3.pop_front();
          check("n3_rand", sum3, exp3);
          got3++;
        end
      end
      if (c < 100) begin
        r = 12'($urandom);
        ops3 = r;
        in_valid3 = 1'b1;
        q3.push_back({2'b00, r[3:0]} + {2'b00, r[7:4]} + {2'b00, r[11:8]});
      end else begin
        in_valid3 = 1'b0;
      end
      tick();
    end
    check("n3_count", got3, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
